exe_mem_pipe_reg: RTL

- Parametrised EXE->MEM pipeline boundary register, successor to the fixed-width always-load stage register.
- Adds valid/ready handshake on both sides, a 2-entry skid buffer (main + skid) for full throughput under downstream stall, and synchronous flush for bubble insertion on branch/exception.
- Sits between the ALU stage and the data-memory stage; carries PC, ALU result, store value, destination register and memory/write-back enables.

---
 rtl/exe_mem_pipe_reg.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM boundary register with valid/ready handshake, main+skid entries, sync flush.
// Optional stall counter enabled by defining STALL_CNT_EN.
module exe_mem_pipe_reg #(
   parameter int PC_W   = 32,
   parameter int DATA_W = 32,
   parameter int DEST_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] st_val_in,
   input  logic [DEST_W-1:0] dest_in,
   input  logic              mem_r_en_in,
   input  logic              mem_w_en_in,
   input  logic              wb_en_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   pc_out,
   output logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] st_val,
   output logic [DEST_W-1:0] dest,
   output logic              mem_r_en,
   output logic              mem_w_en,
   output logic              wb_en
`ifdef STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] st;
      logic [DEST_W-1:0] dest;
      logic              mem_r;
      logic              mem_w;
      logic              wb;
   } ent_t;

   ent_t main_q, main_d;
   ent_t skid_q, skid_d;
   ent_t in_ent;
   logic ov_q, ov_d;
   logic sv_q, sv_d;
   logic accept;
   logic drain;
   logic main_free;

   assign in_ent = '{
      pc:    pc_in,
      alu:   alu_result_in,
      st:    st_val_in,
      dest:  dest_in,
      mem_r: mem_r_en_in,
      mem_w: mem_w_en_in,
      wb:    wb_en_in
   };

   // in_ready depends only on state, so out_ready never reaches it
   assign in_ready  = ~sv_q;
   assign accept    = in_valid & in_ready;
   assign drain     = ov_q & out_ready;
   assign main_free = ~ov_q | drain;

   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      ov_d   = ov_q;
      sv_d   = sv_q;
      if (flush) begin
         ov_d         = 1'b0;
         sv_d         = 1'b0;
         main_d.mem_r = 1'b0;
         main_d.mem_w = 1'b0;
         main_d.wb    = 1'b0;
      end else if (main_free) begin
         if (sv_q) begin
            main_d = skid_q;
            ov_d   = 1'b1;
            sv_d   = accept;
            if (accept) skid_d = in_ent;
         end else if (accept) begin
            main_d = in_ent;
            ov_d   = 1'b1;
         end else begin
            ov_d         = 1'b0;
            main_d.mem_r = 1'b0;
            main_d.mem_w = 1'b0;
            main_d.wb    = 1'b0;
         end
      end else if (accept) begin
         skid_d = in_ent;
         sv_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q <= '0;
         skid_q <= '0;
         ov_q   <= 1'b0;
         sv_q   <= 1'b0;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
         ov_q   <= ov_d;
         sv_q   <= sv_d;
      end
   end

   assign out_valid  = ov_q;
   assign pc_out     = main_q.pc;
   assign alu_result = main_q.alu;
   assign st_val     = main_q.st;
   assign dest       = main_q.dest;
   assign mem_r_en   = main_q.mem_r;
   assign mem_w_en   = main_q.mem_w;
   assign wb_en      = main_q.wb;

`ifdef STALL_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // saturating; flush deliberately leaves it alone
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (ov_q && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign stall_cnt = cnt_q;
`endif

endmodule
